// File: rtl/logring_pkg.sv
// Shared constants for the logring circular log buffer: register map,
// control/status bit positions and the drop counter width.
package logring_pkg;

    localparam int unsigned DROP_W = 16;

    // Register select values on addr
    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_CTRL = 2'd1;
    localparam logic [1:0] ADDR_DROP = 2'd2;
    localparam logic [1:0] ADDR_RSVD = 2'd3;

    // Control word bit positions (ctrl write)
    localparam int unsigned CTRL_COMMIT  = 0;
    localparam int unsigned CTRL_RELEASE = 1;
    localparam int unsigned CTRL_CLEAR   = 2;
    localparam int unsigned CTRL_OVWR    = 3;
    localparam int unsigned CTRL_CLRFLG  = 4;

    // Status word bit positions (ctrl read)
    localparam int unsigned ST_GET_LSB = 0;
    localparam int unsigned ST_PUT_LSB = 8;
    localparam int unsigned ST_CNT_LSB = 16;
    localparam int unsigned ST_EMPTY   = 24;
    localparam int unsigned ST_FULL    = 25;
    localparam int unsigned ST_OVFL    = 26;
    localparam int unsigned ST_TRUNC   = 27;
    localparam int unsigned ST_OVWR    = 28;

endpackage

// File: rtl/logring_ram.sv
// Byte-wide storage for the log entries: one write port, one synchronous
// read port with registered output. Contents are deliberately not reset.
module logring_ram #(
    parameter int unsigned DEPTH = 2048,
    parameter int unsigned AW    = 11
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    dout
);

    logic [7:0] mem [DEPTH];

    // Write port and registered read port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        dout <= mem[raddr];
    end

endmodule

// File: rtl/logring.sv
// Hardware-managed circular log buffer on a 4-word CPU I/O bus slave.
// The driver writes bytes into the put entry and commits; the reader
// drains the get entry byte by byte and releases it.
module logring
    import logring_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = 32,
    parameter int unsigned SLOTS       = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stb,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ack
);

    localparam int unsigned IX_W  = $clog2(NUM_ENTRIES);
    localparam int unsigned PTR_W = $clog2(SLOTS);
    localparam int unsigned CNT_W = IX_W + 1;
    localparam int unsigned AW    = IX_W + PTR_W;

    typedef enum logic {
        RD_IDLE,
        RD_ACK
    } rd_state_t;

    rd_state_t rd_state, rd_state_nxt;

    logic [IX_W-1:0]   put_ix, put_ix_nxt;
    logic [IX_W-1:0]   get_ix, get_ix_nxt;
    logic [CNT_W-1:0]  count, count_nxt;
    // One extra bit: MSB set means the entry is filled and further bytes drop
    logic [PTR_W:0]    wr_cnt, wr_cnt_nxt;
    logic [PTR_W-1:0]  rd_ptr, rd_ptr_nxt;
    logic              ovfl, ovfl_nxt;
    logic              trunc, trunc_nxt;
    logic              ovwr, ovwr_nxt;
    logic [DROP_W-1:0] drops, drops_nxt;

    logic              data_rd_req;
    logic              ram_we;
    logic [7:0]        ram_dout;
    logic              empty, full;
    logic [31:0]       status;
    logic              unused_data;

    assign data_rd_req = stb && !we && (addr == ADDR_DATA);
    assign empty       = (count == '0);
    assign full        = (count == CNT_W'(NUM_ENTRIES));
    assign unused_data = ^data_in[31:8];

    assign status = {3'b0, ovwr, trunc, ovfl, full, empty,
                     8'(count), 8'(put_ix), 8'(get_ix)};

    logring_ram #(
        .DEPTH(NUM_ENTRIES * SLOTS),
        .AW   (AW)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr({put_ix, wr_cnt[PTR_W-1:0]}),
        .wdata(data_in[7:0]),
        .raddr({get_ix, rd_ptr}),
        .dout (ram_dout)
    );

    // Data-read wait-state tracker register
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state <= RD_IDLE;
        end else begin
            rd_state <= rd_state_nxt;
        end
    end

    // Data reads ack one cycle after the strobe is sampled; all else ack at once
    always_comb begin
        rd_state_nxt = rd_state;
        ack          = 1'b0;
        case (rd_state)
            RD_IDLE: begin
                if (data_rd_req) begin
                    rd_state_nxt = RD_ACK;
                end else if (stb && !rst) begin
                    ack = 1'b1;
                end
            end
            RD_ACK: begin
                rd_state_nxt = RD_IDLE;
                ack          = stb && !rst;
            end
            default: rd_state_nxt = RD_IDLE;
        endcase
    end

    // Read data mux, zero whenever no read is being acknowledged
    always_comb begin
        data_out = '0;
        if (ack && !we) begin
            case (addr)
                ADDR_DATA: data_out = empty ? 32'h0 : 32'(ram_dout);
                ADDR_CTRL: data_out = status;
                ADDR_DROP: data_out = 32'(drops);
                default:   data_out = '0;
            endcase
        end
    end

    // Bus access side effects; ctrl bits act in order clear, release, commit
    always_comb begin
        put_ix_nxt = put_ix;
        get_ix_nxt = get_ix;
        count_nxt  = count;
        wr_cnt_nxt = wr_cnt;
        rd_ptr_nxt = rd_ptr;
        ovfl_nxt   = ovfl;
        trunc_nxt  = trunc;
        ovwr_nxt   = ovwr;
        drops_nxt  = drops;
        ram_we     = 1'b0;
        if (ack) begin
            case (addr)
                ADDR_DATA: begin
                    if (we) begin
                        if (!wr_cnt[PTR_W]) begin
                            ram_we     = 1'b1;
                            wr_cnt_nxt = wr_cnt + (PTR_W+1)'(1);
                        end else begin
                            trunc_nxt = 1'b1;
                        end
                    end else if (!empty) begin
                        rd_ptr_nxt = rd_ptr + PTR_W'(1);
                    end
                end
                ADDR_CTRL: begin
                    if (we) begin
                        ovwr_nxt = data_in[CTRL_OVWR];
                        if (data_in[CTRL_CLRFLG]) begin
                            ovfl_nxt  = 1'b0;
                            trunc_nxt = 1'b0;
                        end
                        if (data_in[CTRL_CLEAR]) begin
                            put_ix_nxt = '0;
                            get_ix_nxt = '0;
                            count_nxt  = '0;
                            wr_cnt_nxt = '0;
                            rd_ptr_nxt = '0;
                        end
                        if (data_in[CTRL_RELEASE] && (count_nxt != '0)) begin
                            get_ix_nxt = get_ix_nxt + IX_W'(1);
                            rd_ptr_nxt = '0;
                            count_nxt  = count_nxt - CNT_W'(1);
                        end
                        if (data_in[CTRL_COMMIT]) begin
                            wr_cnt_nxt = '0;
                            if (count_nxt != CNT_W'(NUM_ENTRIES)) begin
                                put_ix_nxt = put_ix_nxt + IX_W'(1);
                                count_nxt  = count_nxt + CNT_W'(1);
                            end else if (ovwr_nxt) begin
                                put_ix_nxt = put_ix_nxt + IX_W'(1);
                                get_ix_nxt = get_ix_nxt + IX_W'(1);
                                rd_ptr_nxt = '0;
                                if (drops_nxt != '1) begin
                                    drops_nxt = drops_nxt + DROP_W'(1);
                                end
                            end else begin
                                ovfl_nxt = 1'b1;
                            end
                        end
                    end else begin
                        rd_ptr_nxt = '0;
                    end
                end
                ADDR_DROP: begin
                    if (we) begin
                        drops_nxt = '0;
                    end
                end
                ADDR_RSVD: ;
                default: ;
            endcase
        end
    end

    // Buffer state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            put_ix <= '0;
            get_ix <= '0;
            count  <= '0;
            wr_cnt <= '0;
            rd_ptr <= '0;
            ovfl   <= 1'b0;
            trunc  <= 1'b0;
            ovwr   <= 1'b0;
            drops  <= '0;
        end else begin
            put_ix <= put_ix_nxt;
            get_ix <= get_ix_nxt;
            count  <= count_nxt;
            wr_cnt <= wr_cnt_nxt;
            rd_ptr <= rd_ptr_nxt;
            ovfl   <= ovfl_nxt;
            trunc  <= trunc_nxt;
            ovwr   <= ovwr_nxt;
            drops  <= drops_nxt;
        end
    end

endmodule
